// File: rtl/mac_result_serializer.sv
// mac_result_serializer
//   Output stage behind mac_top. When mac_top reports a finished result, this
//   block performs a one-cycle read of the wide C vector and copies it into a
//   shadow register. It then streams the elements to the host one per beat
//   over valid/ready. mac_top is free for its next job while the stream drains.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   mac_val    in   mac_top result available
//   mac_rdy    out  handshake back to mac_top (REQ state only)
//   mac_re     out  read enable for C (REQ state only)
//   c_data_in  in   packed C vector; element i = [i*W +: W]
//   out_val    out  stream element valid
//   out_rdy    in   downstream ready
//   out_data   out  current element
//   out_idx    out  row-major index of the current element
//   out_last   out  high with the final element
//   busy       out  high whenever the FSM is not IDLE
//
// state  | meaning
// IDLE   | waiting for mac_val
// REQ    | mac_rdy/mac_re asserted for one cycle
// LOAD   | mac_top drives C; shadow captures it at the end of the cycle
// STREAM | present shadow[idx] until the last beat is accepted
module mac_result_serializer #(
  parameter int  param_M          = 4,
  parameter int  param_N          = 4,
  parameter int  DATA_WIDTH_FINAL = 16,
  localparam int NUM_ELEM         = param_M * param_N,
  localparam int IDX_W            = $clog2(NUM_ELEM)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 mac_val,
  output logic                                 mac_rdy,
  output logic                                 mac_re,
  input  logic [NUM_ELEM*DATA_WIDTH_FINAL-1:0] c_data_in,
  output logic                                 out_val,
  input  logic                                 out_rdy,
  output logic [DATA_WIDTH_FINAL-1:0]          out_data,
  output logic [IDX_W-1:0]                     out_idx,
  output logic                                 out_last,
  output logic                                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    LOAD   = 2'd2,
    STREAM = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [DATA_WIDTH_FINAL-1:0] shadow_q [NUM_ELEM];
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        last_elem;
  logic                        beat;

  assign last_elem = (idx_q == IDX_W'(NUM_ELEM - 1));
  assign beat      = (state_q == STREAM) && out_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // idx only wraps through the last-beat rule, never through counter overflow.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (mac_val) state_d = REQ;
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        state_d = STREAM;
        idx_d   = '0;
      end
      STREAM: begin
        if (beat) begin
          if (last_elem) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // The shadow is written only in LOAD, so c_data_in may change freely while streaming.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q <= '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      if (state_q == LOAD) begin
        for (int i = 0; i < NUM_ELEM; i++) begin
          shadow_q[i] <= c_data_in[i*DATA_WIDTH_FINAL +: DATA_WIDTH_FINAL];
        end
      end
    end
  end

  // Every output depends only on the state and registers. Nothing here is combinational from an input.
  always_comb begin
    mac_rdy  = 1'b0;
    mac_re   = 1'b0;
    out_val  = 1'b0;
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      REQ: begin
        mac_rdy = 1'b1;
        mac_re  = 1'b1;
      end
      STREAM: begin
        out_val  = 1'b1;
        out_data = shadow_q[idx_q];
        out_idx  = idx_q;
        out_last = last_elem;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mac_result_serializer.sv
module tb_mac_result_serializer;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int NE = M * N;
  localparam int IW = 4;

  // Model phase codes: idle, request, load, or a stream position 0..NE-1.
  localparam int P_IDLE = -3;
  localparam int P_REQ  = -2;
  localparam int P_LOAD = -1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            mac_val = 1'b0;
  logic            mac_rdy, mac_re;
  logic [NE*W-1:0] c_data_in = '0;
  logic            out_val;
  logic            out_rdy = 1'b1;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;

  int errors = 0;
  int checks = 0;

  mac_result_serializer #(.param_M(M), .param_N(N), .DATA_WIDTH_FINAL(W)) dut (
    .clk(clk), .rstn(rstn), .mac_val(mac_val), .mac_rdy(mac_rdy), .mac_re(mac_re),
    .c_data_in(c_data_in), .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a phase number plus the captured copy of C.
  int           m_ph = P_IDLE;
  logic [W-1:0] m_elem [NE];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ph = P_IDLE;
    end else if (m_ph == P_IDLE) begin
      if (mac_val) m_ph = P_REQ;
    end else if (m_ph == P_REQ) begin
      m_ph = P_LOAD;
    end else if (m_ph == P_LOAD) begin
      for (int i = 0; i < NE; i++) m_elem[i] = c_data_in[i*W +: W];
      m_ph = 0;
    end else if (out_rdy) begin
      m_ph = (m_ph == NE - 1) ? P_IDLE : m_ph + 1;
    end
  end

  // Per-cycle comparison and event log, sampled on the falling edge.
  logic [W-1:0] got_q[$];
  int           re_cnt = 0;
  int           re_cyc = 0;
  int           rise_cyc = 0;
  int           last_beat_cyc = 0;
  logic         prev_val = 1'b0;
  logic         prev_rdy = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [IW-1:0] prev_idx = '0;

  always @(negedge clk) begin
    if (rstn) begin
      chk("mac_re", 32'(mac_re), 32'(m_ph == P_REQ));
      chk("mac_rdy", 32'(mac_rdy), 32'(m_ph == P_REQ));
      chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
      chk("out_val", 32'(out_val), 32'(m_ph >= 0));
      if (m_ph >= 0) begin
        chk("out_data", 32'(out_data), 32'(m_elem[m_ph]));
        chk("out_idx", 32'(out_idx), 32'(m_ph));
        chk("out_last", 32'(out_last), 32'(m_ph == NE - 1));
      end
      if (prev_val && !prev_rdy && out_val) begin
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_idx", 32'(out_idx), 32'(prev_idx));
      end
      if (mac_re) begin
        re_cnt++;
        re_cyc = cyc;
      end
      if (out_val && !prev_val) rise_cyc = cyc;
      if (out_val && out_rdy) begin
        got_q.push_back(out_data);
        if (out_last) last_beat_cyc = cyc;
      end
      prev_val  = out_val;
      prev_rdy  = out_rdy;
      prev_data = out_data;
      prev_idx  = out_idx;
    end else begin
      prev_val = 1'b0;
    end
  end

  // Ready driver: constant 1 or a per-cycle coin flip.
  bit rnd_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
  end

  logic [W-1:0] exp_arr [NE];

  task automatic fill_seq(input int base);
    for (int i = 0; i < NE; i++) begin
      exp_arr[i] = W'(base + i);
      c_data_in[i*W +: W] = W'(base + i);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NE; i++) begin
      exp_arr[i] = W'($urandom);
      c_data_in[i*W +: W] = exp_arr[i];
    end
  endtask

  task automatic pulse_val();
    @(posedge clk); #1 mac_val = 1'b1;
    @(posedge clk); #1 mac_val = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (got_q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d beats expected %0d", got_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string nm, input int offs);
    chk({nm, "_len"}, 32'(got_q.size() >= offs + NE), 32'd1);
    for (int i = 0; i < NE; i++) begin
      if (offs + i < got_q.size()) chk(nm, 32'(got_q[offs + i]), 32'(exp_arr[i]));
    end
  endtask

  int re0;
  int a_m [NE];
  int c_m [NE];
  int s;

  initial begin
    // Reset state.
    #3;
    chk("rst_mac_rdy", 32'(mac_rdy), 0);
    chk("rst_mac_re", 32'(mac_re), 0);
    chk("rst_out_val", 32'(out_val), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // T2: basic stream 100..115 with out_rdy held high.
    fill_seq(100);
    got_q.delete();
    re0 = re_cnt;
    pulse_val();
    wait_got(NE, 60);
    for (int i = 0; i < NE; i++) chk("t2_lit", 32'(got_q[i]), 32'(100 + i));
    chk("t2_re_once", 32'(re_cnt - re0), 1);
    repeat (3) @(posedge clk);
    #1 chk("t2_idle", 32'(busy), 0);

    // T3: golden C = A*B with A = B = 0..15 row-major.
    for (int i = 0; i < NE; i++) a_m[i] = i;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += a_m[r*N + k] * a_m[k*N + c];
        c_m[r*N + c] = s;
      end
    for (int i = 0; i < NE; i++) begin
      exp_arr[i] = W'(c_m[i]);
      c_data_in[i*W +: W] = W'(c_m[i]);
    end
    got_q.delete();
    pulse_val();
    wait_got(NE, 60);
    chk("t3_c0", 32'(got_q[0]), 56);
    chk("t3_c1", 32'(got_q[1]), 62);
    chk("t3_c15", 32'(got_q[15]), 506);
    check_stream("t3_seq", 0);

    // T4: random backpressure.
    fill_seq(100);
    got_q.delete();
    rnd_rdy = 1'b1;
    pulse_val();
    wait_got(NE, 400);
    rnd_rdy = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < NE; i++) chk("t4_lit", 32'(got_q[i]), 32'(100 + i));

    // T5: C changes after LOAD and mac_val pulses mid-stream are ignored.
    fill_seq(100);
    got_q.delete();
    re0 = re_cnt;
    pulse_val();
    begin
      int k = 0;
      while (!out_val && k < 20) begin @(posedge clk); #1; k++; end
      chk("t5_stream_start", 32'(out_val), 1);
    end
    c_data_in = '1;
    @(posedge clk); #1 mac_val = 1'b1;
    @(posedge clk); #1 mac_val = 1'b0;
    repeat (2) @(posedge clk);
    #1 mac_val = 1'b1;
    @(posedge clk); #1 mac_val = 1'b0;
    wait_got(NE, 60);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < NE; i++) chk("t5_lit", 32'(got_q[i]), 32'(100 + i));
    chk("t5_re_once", 32'(re_cnt - re0), 1);

    // T6: mac_val held through the end of the stream gives a back-to-back restart.
    fill_seq(100);
    got_q.delete();
    re0 = re_cnt;
    @(posedge clk); #1 mac_val = 1'b1;
    begin
      int k = 0;
      while (re_cnt < re0 + 2 && k < 80) begin @(posedge clk); #2; k++; end
      chk("t6_second_req", 32'(re_cnt - re0), 2);
      mac_val = 1'b0;
      k = 0;
      while (!out_val && k < 20) begin @(posedge clk); #2; k++; end
      @(negedge clk); #1;
    end
    // Last beat accepted at edge k: REQ follows edge k+1, out_val follows edge k+3.
    chk("t6_req_gap", 32'(re_cyc - last_beat_cyc), 2);
    chk("t6_val_gap", 32'(rise_cyc - last_beat_cyc), 4);
    wait_got(2 * NE, 80);
    check_stream("t6_first", 0);
    check_stream("t6_second", NE);

    // Random transactions with random data and backpressure.
    for (int t = 0; t < 6; t++) begin
      fill_rand();
      got_q.delete();
      rnd_rdy = 1'($urandom_range(0, 1));
      pulse_val();
      wait_got(NE, 400);
      rnd_rdy = 1'b0;
      out_rdy = 1'b1;
      check_stream("rnd_seq", 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // T1: asynchronous reset in the middle of a stream.
    fill_seq(200);
    got_q.delete();
    rnd_rdy = 1'b1;
    pulse_val();
    repeat (6) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t1_mac_rdy", 32'(mac_rdy), 0);
    chk("t1_mac_re", 32'(mac_re), 0);
    chk("t1_out_val", 32'(out_val), 0);
    chk("t1_out_data", 32'(out_data), 0);
    chk("t1_out_idx", 32'(out_idx), 0);
    chk("t1_out_last", 32'(out_last), 0);
    chk("t1_busy", 32'(busy), 0);
    @(posedge clk); #1 rstn = 1'b1;
    got_q.delete();
    repeat (8) @(posedge clk);
    #1;
    chk("t1_no_beats", 32'(got_q.size()), 0);
    chk("t1_idle", 32'(busy), 0);
    rnd_rdy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
